// File: rtl/decode_issue.sv
// -----------------------------------------------------------------------------
// decode_issue
//   Decode/issue stage in front of the ALU. Accepts one 32-bit RV32I
//   instruction per cycle from fetch over a valid/ready handshake, decodes
//   OP (0110011) and OP-IMM (0010011), reads the locally owned register file
//   and presents one registered operand bundle to execute. Write-back enters
//   on a separate port. A one-bit-per-register scoreboard blocks issue on
//   RAW and WAW hazards until the producing write-back arrives.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     fetch handshake; in_instr is the offered word
//   out_valid/out_ready   execute handshake for the operand bundle
//   out_rs1, out_rs2      source operand values
//   out_imm, out_imm_sel  immediate operand and OP-IMM flag
//   out_funct3/7, out_rd  ALU function fields and destination register
//   out_illegal           opcode was neither OP nor OP-IMM
//   wb_en/wb_rd/wb_data   register write-back
// -----------------------------------------------------------------------------
module decode_issue #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rs1,
  output logic [DATA_W-1:0] out_rs2,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_imm_sel,
  output logic [2:0]        out_funct3,
  output logic [6:0]        out_funct7,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_illegal,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data
);

  localparam int NREG = 2 ** REG_AW;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  typedef struct packed {
    logic [DATA_W-1:0] rs1;
    logic [DATA_W-1:0] rs2;
    logic [DATA_W-1:0] imm;
    logic              imm_sel;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [REG_AW-1:0] rd;
    logic              illegal;
  } bundle_t;

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  logic [6:0]        opcode;
  logic [REG_AW-1:0] rs1_a;
  logic [REG_AW-1:0] rs2_a;
  logic [REG_AW-1:0] rd_a;
  logic [2:0]        funct3;
  logic              is_op;
  logic              is_opimm;
  logic              is_illegal;

  assign opcode     = in_instr[6:0];
  assign rs1_a      = in_instr[19:15];
  assign rs2_a      = in_instr[24:20];
  assign rd_a       = in_instr[11:7];
  assign funct3     = in_instr[14:12];
  assign is_op      = (opcode == OPC_OP);
  assign is_opimm   = (opcode == OPC_OPIMM);
  assign is_illegal = !is_op && !is_opimm;

  // ---------------------------------------------------------------------------
  // Register file with same-cycle write-back bypass
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rf [NREG];
  logic              wb_write;

  assign wb_write = wb_en && (wb_rd != '0);

  // NOTE: this array is reset element by element because a cleared register
  // file after reset is part of the contract; that forces flops rather than
  // RAM macros, which is acceptable at 32 entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_write) begin
      rf[wb_rd] <= wb_data;
    end
  end

  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;

  // NOTE: every output of a combinational block gets a default on entry so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1_a != '0) rs1_val = (wb_en && wb_rd == rs1_a) ? wb_data : rf[rs1_a];
    if (rs2_a != '0) rs2_val = (wb_en && wb_rd == rs2_a) ? wb_data : rf[rs2_a];
  end

  // ---------------------------------------------------------------------------
  // Scoreboard and hazard detection
  // ---------------------------------------------------------------------------
  logic [NREG-1:0] sb;
  logic [NREG-1:0] wb_mask;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] pend;
  logic [NREG-1:0] sb_next;
  logic            hazard;
  logic            accept;

  // A write-back landing this cycle already resolves its register, so it no
  // longer counts as pending for the instruction being examined.
  assign wb_mask = wb_en ? (NREG'(1) << wb_rd) : '0;
  assign pend    = sb & ~wb_mask & ~NREG'(1);

  // Illegal instructions neither read nor write registers, so they never wait.
  assign hazard = !is_illegal &&
                  (pend[rs1_a] || (is_op && pend[rs2_a]) || pend[rd_a]);

  assign in_ready = rst_n && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  assign set_mask = (accept && !is_illegal && rd_a != '0) ? (NREG'(1) << rd_a) : '0;
  // Clear is applied before set so a same-register collision leaves it pending.
  assign sb_next  = (sb & ~wb_mask) | set_mask;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb <= '0;
    else        sb <= sb_next;
  end

  // ---------------------------------------------------------------------------
  // Decode into the next bundle
  // ---------------------------------------------------------------------------
  bundle_t dec;

  always_comb begin
    dec        = '0;
    dec.funct3 = funct3;
    if (is_op) begin
      dec.rs1    = rs1_val;
      dec.rs2    = rs2_val;
      dec.funct7 = in_instr[31:25];
      dec.rd     = rd_a;
    end else if (is_opimm) begin
      dec.rs1     = rs1_val;
      dec.rs2     = rs2_val;
      dec.imm_sel = 1'b1;
      dec.rd      = rd_a;
      if (funct3 == 3'b001 || funct3 == 3'b101) begin
        // Shifts: shamt is unsigned and funct7 distinguishes SRLI/SRAI.
        dec.imm    = DATA_W'(in_instr[24:20]);
        dec.funct7 = in_instr[31:25];
      end else begin
        // Upper immediate bits are data here, not funct7; zeroing funct7
        // keeps e.g. a negative ADDI from looking like SUB to the ALU.
        dec.imm    = DATA_W'($signed(in_instr[31:20]));
        dec.funct7 = '0;
      end
    end else begin
      dec.illegal = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output bundle register
  // ---------------------------------------------------------------------------
  bundle_t bundle_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      bundle_q  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      bundle_q  <= dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_rs1     = bundle_q.rs1;
  assign out_rs2     = bundle_q.rs2;
  assign out_imm     = bundle_q.imm;
  assign out_imm_sel = bundle_q.imm_sel;
  assign out_funct3  = bundle_q.funct3;
  assign out_funct7  = bundle_q.funct7;
  assign out_rd      = bundle_q.rd;
  assign out_illegal = bundle_q.illegal;

endmodule

// File: tb/tb_decode_issue.sv
// -----------------------------------------------------------------------------
// tb_decode_issue
//   Directed bench for decode_issue. Inputs change on the falling edge;
//   combinational in_ready is sampled 1 time unit later and registered
//   outputs are sampled on the falling edge following the capturing edge.
// -----------------------------------------------------------------------------
module tb_decode_issue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rs1;
  logic [31:0] out_rs2;
  logic [31:0] out_imm;
  logic        out_imm_sel;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rd;
  logic        out_illegal;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  decode_issue #(.DATA_W(32), .REG_AW(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rs1    (out_rs1),
    .out_rs2    (out_rs2),
    .out_imm    (out_imm),
    .out_imm_sel(out_imm_sel),
    .out_funct3 (out_funct3),
    .out_funct7 (out_funct7),
    .out_rd     (out_rd),
    .out_illegal(out_illegal),
    .wb_en      (wb_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b0;
    wb_en     = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;

    // Reset state
    step();
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_rs1",   out_rs1,        32'd0);
    check("rst_out_rd",    32'(out_rd),    32'd0);
    step();
    rst_n = 1'b1;

    // 1: wb x1=5, x2=7, ADD x3,x1,x2
    step(); wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
    step(); wb_rd = 5'd2; wb_data = 32'd7;
    step(); wb_en = 1'b0; in_valid = 1'b1; in_instr = 32'h002081B3; out_ready = 1'b1;
    #1 check("t1_in_ready", 32'(in_ready), 32'd1);
    // 2: ADDI x4,x0,-1024 offered back to back
    step(); in_instr = 32'hC0000213;
    check("t1_valid",   32'(out_valid),   32'd1);
    check("t1_rs1",     out_rs1,          32'd5);
    check("t1_rs2",     out_rs2,          32'd7);
    check("t1_imm",     out_imm,          32'd0);
    check("t1_imm_sel", 32'(out_imm_sel), 32'd0);
    check("t1_funct3",  32'(out_funct3),  32'd0);
    check("t1_funct7",  32'(out_funct7),  32'd0);
    check("t1_rd",      32'(out_rd),      32'd3);
    check("t1_illegal", 32'(out_illegal), 32'd0);
    #1 check("t2_in_ready", 32'(in_ready), 32'd1);
    step(); in_instr = 32'h4030D293;
    check("t2_addi_imm",     out_imm,          32'hFFFFFC00);
    check("t2_addi_funct7",  32'(out_funct7),  32'd0);
    check("t2_addi_imm_sel", 32'(out_imm_sel), 32'd1);
    check("t2_addi_rd",      32'(out_rd),      32'd4);
    check("t2_addi_rs1",     out_rs1,          32'd0);
    #1 check("t2_srai_in_ready", 32'(in_ready), 32'd1);
    step(); in_valid = 1'b0;
    check("t2_srai_imm",    out_imm,         32'd3);
    check("t2_srai_funct7", 32'(out_funct7), 32'h20);
    check("t2_srai_funct3", 32'(out_funct3), 32'd5);
    check("t2_srai_rs1",    out_rs1,         32'd5);
    check("t2_srai_rd",     32'(out_rd),     32'd5);

    // 3: x3 pending from test 1 (WAW) stalls a second ADD x3
    step(); in_valid = 1'b1; in_instr = 32'h002081B3;
    check("t3_drained", 32'(out_valid), 32'd0);
    #1 check("t3_waw_stall", 32'(in_ready), 32'd0);
    // Retire x3, x4, x5; x3 write-back bypasses the stall in the same cycle
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'd9;
    #1 check("t3_waw_release", 32'(in_ready), 32'd1);
    step(); wb_rd = 5'd4; wb_data = 32'd1; in_instr = r_add(5'd6, 5'd3, 5'd3);
    check("t3_add3_rs1", out_rs1, 32'd5);
    check("t3_add3_rs2", out_rs2, 32'd7);
    for (int i = 0; i < 3; i++) begin
      #1 check("t3_raw_stall", 32'(in_ready), 32'd0);
      step(); wb_rd = 5'd5;
    end
    wb_rd = 5'd3; wb_data = 32'h55;
    #1 check("t3_raw_release", 32'(in_ready), 32'd1);
    step(); wb_en = 1'b0; out_ready = 1'b0; in_instr = i_addi(5'd7, 5'd1, 12'd5);
    check("t3_x6_valid", 32'(out_valid), 32'd1);
    check("t3_x6_rs1",   out_rs1,        32'h55);
    check("t3_x6_rs2",   out_rs2,        32'h55);
    check("t3_x6_rd",    32'(out_rd),    32'd6);

    // 4: backpressure for 4 cycles, then back-to-back accepts
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t4_hold_ready", 32'(in_ready),  32'd0);
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_rs1",   out_rs1,        32'h55);
      check("t4_hold_rd",    32'(out_rd),    32'd6);
      step();
    end
    out_ready = 1'b1;
    #1 check("t4_release_ready", 32'(in_ready), 32'd1);
    step(); in_instr = i_addi(5'd8, 5'd2, 12'hFFF);
    check("t4_b2b1_valid", 32'(out_valid), 32'd1);
    check("t4_b2b1_rd",    32'(out_rd),    32'd7);
    check("t4_b2b1_rs1",   out_rs1,        32'd5);
    check("t4_b2b1_imm",   out_imm,        32'd5);
    #1 check("t4_b2b2_ready", 32'(in_ready), 32'd1);
    step(); in_valid = 1'b0;
    check("t4_b2b2_valid", 32'(out_valid), 32'd1);
    check("t4_b2b2_rd",    32'(out_rd),    32'd8);
    check("t4_b2b2_rs1",   out_rs1,        32'd7);
    check("t4_b2b2_imm",   out_imm,        32'hFFFFFFFF);
    step();
    check("t4_drain_valid", 32'(out_valid), 32'd0);

    // 5: write to x0 ignored; illegal opcode ignores hazards and sets nothing
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
    step(); wb_en = 1'b0; in_valid = 1'b1; in_instr = r_add(5'd1, 5'd0, 5'd0);
    #1 check("t5_x0_ready", 32'(in_ready), 32'd1);
    // LW-style word: rd=x9, rs1=x6 (x6 still pending)
    step(); in_instr = {12'd4, 5'd6, 3'b010, 5'd9, 7'b0000011};
    check("t5_x0_rs1", out_rs1, 32'd0);
    check("t5_x0_rs2", out_rs2, 32'd0);
    check("t5_x0_rd",  32'(out_rd), 32'd1);
    #1 check("t5_ill_ready", 32'(in_ready), 32'd1);
    step(); in_instr = r_add(5'd10, 5'd9, 5'd9);
    check("t5_ill_flag",   32'(out_illegal), 32'd1);
    check("t5_ill_rd",     32'(out_rd),      32'd0);
    check("t5_ill_rs1",    out_rs1,          32'd0);
    check("t5_ill_imm",    out_imm,          32'd0);
    check("t5_ill_funct7", 32'(out_funct7),  32'd0);
    #1 check("t5_no_sb_x9", 32'(in_ready), 32'd1);

    // 6: reset with a valid bundle and x3 pending
    step(); in_instr = i_addi(5'd3, 5'd0, 12'd1);
    #1 check("t6_x3_ready", 32'(in_ready), 32'd1);
    step(); in_valid = 1'b0; out_ready = 1'b0;
    check("t6_pre_valid", 32'(out_valid), 32'd1);
    check("t6_pre_rd",    32'(out_rd),    32'd3);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_ready", 32'(in_ready),  32'd0);
    check("t6_rst_rd",    32'(out_rd),    32'd0);
    step(); rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h002081B3;
    #1 check("t6_sb_clear", 32'(in_ready), 32'd1);
    step(); in_valid = 1'b0;
    check("t6_post_valid", 32'(out_valid), 32'd1);
    check("t6_rf_x1_zero", out_rs1,        32'd0);
    check("t6_rf_x2_zero", out_rs2,        32'd0);
    check("t6_post_rd",    32'(out_rd),    32'd3);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
